// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and the byte-lane merge helper for dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int DMEM_DATA_W = 64;
  localparam int BE_W        = DMEM_DATA_W / 8;

  // Merge helper is sized for the widest supported word; callers cast in and out.
  localparam int MERGE_W    = 512;
  localparam int MERGE_BE_W = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]    old_word,
    input logic [MERGE_W-1:0]    new_word,
    input logic [MERGE_BE_W-1:0] be
  );
    logic [MERGE_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : DEPTH x DATA_W storage, byte-enabled sync write, sync read.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_waddr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [ADDR_W-1:0]   i_raddr,
  output logic [DATA_W-1:0]   o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        r_mem[i_waddr] <= DATA_W'(be_merge(MERGE_W'(r_mem[i_waddr]),
                                           MERGE_W'(i_wdata),
                                           MERGE_BE_W'(i_be)));
      end
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Handshaked multi-cycle data memory slave with byte-enabled stores.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                busy
);

  localparam int CNT_W = $clog2(LATENCY) + 1;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_be;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;
  logic                r_busy;

  logic                w_in_range;
  logic                w_we;
  logic [ADDR_W-1:0]   w_raddr;
  logic [DATA_W-1:0]   w_rdata;

  generate
    if (DEPTH >= (1 << ADDR_W)) begin : g_full_range
      assign w_in_range = 1'b1;
    end else begin : g_partial_range
      assign w_in_range = ({1'b0, r_addr} < (ADDR_W+1)'(DEPTH));
    end
  endgenerate

  // The read port samples the live request address while idle so that the
  // word is already registered by ACCESS even when LATENCY is 1.
  assign w_raddr = (r_state == IDLE) ? req_addr : r_addr;
  assign w_we    = (r_state == ACCESS) && r_write && w_in_range;

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_be        <= req_be;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_cnt       <= CNT_W'(LATENCY - 1);
            if (LATENCY == 1) r_state <= ACCESS;
            else              r_state <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= ACCESS;
        end
        ACCESS: begin
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
          if (!w_in_range) begin
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b1;
          end else if (r_write) begin
            r_resp_rdata <= '0;
          end else begin
            r_resp_rdata <= w_rdata;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Randomized self-checking bench over three latency/depth configs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int NI = 3;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  function automatic int depth_of(input int k);
    return (k == 0) ? 24 : 32;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n      [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_write  [NI];
  logic [4:0]  req_addr   [NI];
  logic [63:0] req_wdata  [NI];
  logic [7:0]  req_be     [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [63:0] resp_rdata [NI];
  logic        resp_err   [NI];
  logic        busy       [NI];

  logic [63:0] model_mem [NI][32];

  int n_checks = 0;
  int n_errors = 0;
  int cur_k    = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .DATA_W  (64),
      .ADDR_W  (5),
      .DEPTH   (depth_of(g)),
      .LATENCY (lat_of(g))
    ) u_dut (
      .clk        (clk),
      .reset_n    (rst_n[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_be     (req_be[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g]),
      .busy       (busy[g])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cfg%0d): got 0x%0h, expected 0x%0h", tag, cur_k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: a plain array, range check and byte-lane overwrite.
  task automatic model_txn(input int k, input logic wr, input logic [4:0] a,
                           input logic [63:0] wd, input logic [7:0] be,
                           output logic [63:0] exp_rd, output logic exp_err);
    exp_rd  = 64'h0;
    exp_err = 1'b0;
    if (int'(a) >= depth_of(k)) begin
      exp_err = 1'b1;
    end else if (wr) begin
      for (int i = 0; i < 8; i++)
        if (be[i]) model_mem[k][a][8*i +: 8] = wd[8*i +: 8];
    end else begin
      exp_rd = model_mem[k][a];
    end
  endtask

  task automatic do_txn(input int k, input logic wr, input logic [4:0] a,
                        input logic [63:0] wd, input logic [7:0] be,
                        input int hold, output logic [63:0] got_rd);
    int n;
    logic [63:0] exp_rd;
    logic        exp_err;
    got_rd       = 64'h0;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    req_be[k]    = be;
    req_valid[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 50) begin step(); n++; end
    if (!req_ready[k]) begin
      check_eq("accept_timeout", 64'(req_ready[k]), 64'h1);
      req_valid[k] = 1'b0;
      return;
    end
    step();
    req_valid[k] = 1'b0;
    req_wdata[k] = ~wd;
    req_addr[k]  = a ^ 5'h1;
    req_be[k]    = ~be;
    req_write[k] = ~wr;
    resp_ready[k] = 1'($urandom_range(0, 1));
    check_eq("busy_after_accept", 64'(busy[k]), 64'h1);
    check_eq("ready_after_accept", 64'(req_ready[k]), 64'h0);
    n = 0;
    while (!resp_valid[k] && n < 50) begin step(); n++; end
    check_eq("latency", 64'(n), 64'(lat_of(k)));
    model_txn(k, wr, a, wd, be, exp_rd, exp_err);
    got_rd = resp_rdata[k];
    check_eq("rdata", resp_rdata[k], exp_rd);
    check_eq("err", 64'(resp_err[k]), 64'(exp_err));
    resp_ready[k] = 1'b0;
    for (int i = 0; i < hold; i++) begin
      req_valid[k] = 1'b1;
      step();
      check_eq("hold_valid", 64'(resp_valid[k]), 64'h1);
      check_eq("hold_rdata", resp_rdata[k], exp_rd);
      check_eq("hold_err", 64'(resp_err[k]), 64'(exp_err));
      check_eq("hold_req_ready", 64'(req_ready[k]), 64'h0);
    end
    req_valid[k]  = 1'b0;
    resp_ready[k] = 1'b1;
    step();
    resp_ready[k] = 1'b0;
    check_eq("post_valid", 64'(resp_valid[k]), 64'h0);
    check_eq("post_req_ready", 64'(req_ready[k]), 64'h1);
    check_eq("post_busy", 64'(busy[k]), 64'h0);
    check_eq("post_err", 64'(resp_err[k]), 64'h0);
  endtask

  task automatic run_suite(input int k);
    logic [63:0] rd;
    int acc_cyc [4];
    int n_acc;
    int n;
    bit seen;
    cur_k = k;

    check_eq("rst_req_ready", 64'(req_ready[k]), 64'h1);
    check_eq("rst_resp_valid", 64'(resp_valid[k]), 64'h0);
    check_eq("rst_busy", 64'(busy[k]), 64'h0);
    check_eq("rst_rdata", resp_rdata[k], 64'h0);
    check_eq("rst_err", 64'(resp_err[k]), 64'h0);

    do_txn(k, 1'b1, 5'd3, 64'h1122334455667788, 8'hFF, 0, rd);
    do_txn(k, 1'b0, 5'd3, 64'h0, 8'h00, 0, rd);
    check_eq("load_full", rd, 64'h1122334455667788);
    do_txn(k, 1'b1, 5'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1, rd);
    do_txn(k, 1'b0, 5'd3, 64'h0, 8'h00, 0, rd);
    check_eq("load_partial", rd, 64'h11223344AAAAAAAA);
    do_txn(k, 1'b1, 5'd3, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0, rd);
    do_txn(k, 1'b0, 5'd3, 64'h0, 8'h00, 4, rd);
    check_eq("load_be0", rd, 64'h11223344AAAAAAAA);

    if (depth_of(k) < 32) begin
      do_txn(k, 1'b1, 5'd30, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, rd);
      do_txn(k, 1'b0, 5'd30, 64'h0, 8'h00, 0, rd);
      do_txn(k, 1'b1, 5'd23, 64'h0123456789ABCDEF, 8'hFF, 0, rd);
      do_txn(k, 1'b0, 5'd23, 64'h0, 8'h00, 0, rd);
      check_eq("load_last_word", rd, 64'h0123456789ABCDEF);
    end

    // Reset while a store is in flight.
    req_write[k] = 1'b1; req_addr[k] = 5'd5; req_wdata[k] = 64'hDEAD; req_be[k] = 8'hFF;
    req_valid[k] = 1'b1;
    step();
    req_valid[k] = 1'b0;
    rst_n[k] = 1'b0;
    step();
    rst_n[k] = 1'b1;
    for (int a = 0; a < 32; a++) model_mem[k][a] = 64'h0;
    seen = 1'b0;
    for (int i = 0; i < lat_of(k) + 3; i++) begin
      if (resp_valid[k]) seen = 1'b1;
      step();
    end
    check_eq("rst_mid_no_resp", 64'(seen), 64'h0);
    check_eq("rst_mid_req_ready", 64'(req_ready[k]), 64'h1);
    check_eq("rst_mid_busy", 64'(busy[k]), 64'h0);
    do_txn(k, 1'b0, 5'd5, 64'h0, 8'h00, 0, rd);
    check_eq("rst_mid_load5", rd, 64'h0);

    // Back-to-back loads with the response side always ready.
    resp_ready[k] = 1'b1;
    req_write[k]  = 1'b0;
    req_addr[k]   = 5'd1;
    req_valid[k]  = 1'b1;
    n_acc = 0;
    n = 0;
    while (n_acc < 4 && n < 200) begin
      if (req_valid[k] && req_ready[k]) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      step();
      n++;
    end
    req_valid[k] = 1'b0;
    check_eq("period_accepts", 64'(n_acc), 64'h4);
    for (int i = 1; i < n_acc; i++)
      check_eq("period", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(lat_of(k) + 2));
    n = 0;
    while (busy[k] && n < 50) begin step(); n++; end
    resp_ready[k] = 1'b0;
    check_eq("period_drain", 64'(busy[k]), 64'h0);

    for (int t = 0; t < 40; t++) begin
      logic [63:0] wd;
      wd = {$urandom(), $urandom()};
      do_txn(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), wd,
             8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), rd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k]      = 1'b0;
      req_valid[k]  = 1'b0;
      req_write[k]  = 1'b0;
      req_addr[k]   = 5'd0;
      req_wdata[k]  = 64'h0;
      req_be[k]     = 8'h0;
      resp_ready[k] = 1'b0;
      for (int a = 0; a < 32; a++) model_mem[k][a] = 64'h0;
    end
    repeat (3) step();
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    step();
    for (int k = 0; k < NI; k++) run_suite(k);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the pipeline's load/store port. It replaces the fixed single-cycle data memory with a handshaked, multi-cycle slave.
- Accepts one request at a time over a valid/ready request channel.
- Models configurable access latency and applies byte-enabled stores.
- Returns read data or write completion over a valid/ready response channel.
- Intended target for the memory-stage stall logic and for bring-up of slower memory models.

Parameters:
DATA_W, 64, data width in bits; must be a multiple of 8
ADDR_W, 5, doubleword-index address width
DEPTH, 32, number of implemented DATA_W words; 1 <= DEPTH <= 2**ADDR_W
LATENCY, 2, cycles from request accept to first resp_valid; must be >= 1

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  reset; synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  doubleword index
req_wdata  in  DATA_W  store data
req_be  in  DATA_W/8  byte enables for a store; bit i covers bits [8i+7:8i]
resp_valid  out  1  response present
resp_ready  in  1  requester accepts the response
resp_rdata  out  DATA_W  load data; 0 for stores and errors
resp_err  out  1  address >= DEPTH
busy  out  1  state != IDLE

Behaviour:
- Reset is synchronous, active-low, and takes priority over everything, including a handshake in the same cycle. Any pending request is dropped; no storage write occurs.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, latency counter=0, all DEPTH storage words = 0.
- FSM states:
  - IDLE: req_ready=1. When req_valid && req_ready, capture write/addr/wdata/be, load counter=LATENCY-1, go to WAIT. If LATENCY==1, go directly to ACCESS.
  - WAIT: req_ready=0. Decrement the counter each cycle; when counter==1, next state is ACCESS.
  - ACCESS: single cycle.
    - Read: resp_rdata <= mem[addr].
    - Write: mem[addr] byte lanes with be=1 <= wdata lanes; resp_rdata <= 0.
    - If addr >= DEPTH: no write, resp_rdata <= 0, resp_err <= 1.
    - Set resp_valid <= 1; go to RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_valid && resp_ready. On handshake: resp_valid <= 0, resp_err <= 0, go to IDLE.
- Latency: a request accepted at edge T gives resp_valid=1 in the cycle after edge T+LATENCY. A response accepted at edge R gives req_ready=1 in the cycle after R. No overlap of requests; the minimum period is LATENCY+2 cycles per transaction.
- req_valid in non-IDLE states is ignored; the requester must hold the request until req_ready.
- Request inputs are sampled only at accept; later changes have no effect.
- A store with be=0 is a no-op write. It still completes normally with resp_err=0.
- Read of a word written by the previous transaction returns the new value, since the write completed before RESP.
- resp_ready asserted outside RESP is ignored.
- Counter width is clog2(LATENCY)+1; there is no wrap-around.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, ACCESS, RESP}
  - localparam BE_W = DATA_W/8
  - function be_merge(old, new, be) returning the byte-merged word
- One sub-module: dmem_array. It holds DEPTH x DATA_W storage with a synchronous byte-enabled write port, a synchronous read port, and synchronous reset clear.
- The FSM, counter and response registers stay in dmem_responder.

Test Plan:
- Store then load (LATENCY=2, DEPTH=32, resp_ready=1): store addr=3, wdata=0x1122334455667788, be=0xFF accepted at edge 0 -> resp_valid high after edge 2, resp_err=0, resp_rdata=0. Then load addr=3 -> resp_rdata=0x1122334455667788.
- Partial store: store addr=3, wdata=0xAAAAAAAAAAAAAAAA, be=0x0F, then load addr=3 -> 0x11223344AAAAAAAA. A store with be=0x00 leaves the word unchanged.
- Backpressure: load addr=3 with resp_ready=0 for 4 cycles -> resp_valid, resp_rdata, resp_err stable, req_ready=0, and a new req_valid is ignored. resp_ready=1 -> req_ready=1 the next cycle.
- Out of range (DEPTH=24): store addr=30, wdata=0xFFFF... -> resp_err=1, resp_rdata=0, no array change. Load addr=30 -> resp_err=1, rdata=0. Load addr=23 -> resp_err=0.
- Reset mid-operation: accept store addr=5, data=0xDEAD; reset_n=0 during WAIT -> resp_valid never asserts, state=IDLE, req_ready=1. A subsequent load addr=5 returns 0.
- LATENCY=1 and LATENCY=5 sweep: resp_valid arrives exactly LATENCY+1 cycles after the accept cycle. Back-to-back transactions with resp_ready=1 give a period of LATENCY+2 cycles.
